// File: rtl/lcd_ctrl.sv
// lcd_ctrl: FIFO-buffered HD44780 8-bit bus writer with a 32-bit status word.
// Define LCD_BUSY_POLL_EN to replace the fixed execution delay with busy-flag polling.
module lcd_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int T_SETUP     = 2,
  parameter int T_PULSE     = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_status,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_data_oe,
  input  logic [7:0]  i_lcd_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(T_EXEC_LONG + 1);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC, P_SETUP, P_PULSE, P_HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [8:0] mem [FIFO_DEPTH];
  logic [8:0] head;
  logic [AW:0] wp, rp, level;
  logic [31:0] level_w;
  logic empty, full, pop, push, ovf, done, busy, en_n, rs_n;
  logic [7:0] data_n;
  assign level   = wp - rp;
  assign level_w = 32'(level);
  assign empty   = level == '0;
  assign full    = level == (AW+1)'(FIFO_DEPTH);
  assign pop     = state == IDLE && !empty;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign push    = i_wr && (!full || pop);
  assign head    = mem[rp[AW-1:0]];
  assign done    = cnt == '0;
  assign busy    = state != IDLE || !empty;
  always_ff @(posedge i_clk) begin
    if (push) mem[wp[AW-1:0]] <= {i_wdata[8], i_wdata[7:0]};
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wp       <= '0;
      rp       <= '0;
      ovf      <= 1'b0;
      o_lcd_on <= 1'b0;
      o_status <= 32'h8;
    end else begin
      wp       <= wp + (AW+1)'(push);
      rp       <= rp + (AW+1)'(pop);
      ovf      <= ovf | (i_wr & ~push);
      o_lcd_on <= i_wr ? i_wdata[31] : o_lcd_on;
      o_status <= {24'b0, (level_w > 15 ? 4'hf : level_w[3:0]), empty, ovf, full, busy};
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      o_lcd_en   <= 1'b0;
      o_lcd_rs   <= 1'b0;
      o_lcd_data <= 8'h00;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      o_lcd_en   <= en_n;
      o_lcd_rs   <= rs_n;
      o_lcd_data <= data_n;
    end
  end
`ifdef LCD_BUSY_POLL_EN
  logic [CW-1:0] tmo;
  logic bf, rw_n, in_poll, unused_in;
  assign in_poll   = state == P_SETUP || state == P_PULSE || state == P_HOLD;
  assign unused_in = ^{i_wdata[30:9], i_lcd_data[6:0]};
  // tmo bounds the whole polling phase; it is armed while the write is in HOLD
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      tmo           <= '0;
      bf            <= 1'b0;
      o_lcd_rw      <= 1'b0;
      o_lcd_data_oe <= 1'b1;
    end else begin
      tmo           <= state == HOLD ? CW'(T_EXEC_LONG - 1) : (tmo == '0 ? tmo : tmo - 1'b1);
      bf            <= state == P_PULSE && done ? i_lcd_data[7] : bf;
      o_lcd_rw      <= rw_n;
      o_lcd_data_oe <= ~rw_n;
    end
  end
`else
  logic long_cmd, unused_in;
  assign long_cmd      = !o_lcd_rs && o_lcd_data != 8'h00 && o_lcd_data < 8'h04;
  assign unused_in     = ^{i_wdata[30:9], i_lcd_data};
  assign o_lcd_rw      = 1'b0;
  assign o_lcd_data_oe = 1'b1;
`endif
  always_comb begin
    state_n = state;
    cnt_n   = done ? '0 : cnt - 1'b1;
    case (state)
      IDLE:    if (pop)  begin state_n = SETUP; cnt_n = CW'(T_SETUP - 1); end
      SETUP:   if (done) begin state_n = PULSE; cnt_n = CW'(T_PULSE - 1); end
      PULSE:   if (done) begin state_n = HOLD;  cnt_n = CW'(T_HOLD - 1);  end
`ifdef LCD_BUSY_POLL_EN
      HOLD:    if (done) begin state_n = P_SETUP; cnt_n = CW'(T_SETUP - 1); end
      P_SETUP: if (done) begin state_n = P_PULSE; cnt_n = CW'(T_PULSE - 1); end
      P_PULSE: if (done) begin state_n = P_HOLD;  cnt_n = CW'(T_HOLD - 1);  end
      P_HOLD:  if (done) begin state_n = bf ? P_SETUP : IDLE; cnt_n = CW'(T_SETUP - 1); end
`else
      HOLD:    if (done) begin state_n = EXEC; cnt_n = long_cmd ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1); end
      EXEC:    if (done) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
`ifdef LCD_BUSY_POLL_EN
    if (in_poll && tmo == '0) state_n = IDLE;
`endif
  end
  // outputs are registered from the next state so pins change exactly on state entry
  always_comb begin
    en_n   = state_n == PULSE || state_n == P_PULSE;
    rs_n   = pop ? head[8] : o_lcd_rs;
    data_n = pop ? head[7:0] : o_lcd_data;
`ifdef LCD_BUSY_POLL_EN
    rw_n   = state_n == P_SETUP || state_n == P_PULSE || state_n == P_HOLD;
    rs_n   = rw_n ? 1'b0 : rs_n;
`endif
  end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed and randomized checks of lcd_ctrl against a timeline model.
module tb_lcd_ctrl;
  localparam int DEPTH = 4, TS = 1, TP = 3, TH = 1, TE = 10, TL = 50;
  logic clk = 0, rst_n = 0, wr = 0;
  logic [31:0] wdata = 0;
  logic [7:0] lcd_din = 0;
  logic [31:0] status;
  logic lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_oe;
  logic [7:0] lcd_data;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  lcd_ctrl #(.FIFO_DEPTH(DEPTH), .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH),
             .T_EXEC(TE), .T_EXEC_LONG(TL)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_wr(wr), .i_wdata(wdata), .o_status(status),
    .o_lcd_on(lcd_on), .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
    .o_lcd_data(lcd_data), .o_lcd_data_oe(lcd_oe), .i_lcd_data(lcd_din));

  // Timeline model: each popped entry occupies the bus for a known number of
  // cycles; the status word shows the state as it was one edge earlier.
  int cyc = 0, t_free = 0, k_pop = -1000;
  logic [8:0] mq[$];
  logic m_on = 0, m_en = 0, m_rs = 0, m_ovf = 0;
  logic [7:0] m_data = 0;
  logic [31:0] m_status = 32'h8;

  task automatic model_step();
    logic [8:0] e;
    logic m_pop, m_push;
    int lvl;
    cyc++;
    if (!rst_n) begin
      mq.delete();
      {m_on, m_en, m_rs, m_ovf} = 4'b0;
      m_data = 0; m_status = 32'h8; t_free = 0; k_pop = -1000;
    end else begin
      lvl = mq.size();
      m_status = {24'b0, 4'(lvl), lvl == 0, m_ovf, lvl == DEPTH, (cyc < t_free) || (lvl != 0)};
      m_pop = cyc >= t_free && lvl > 0;
      m_push = wr && (lvl < DEPTH || m_pop);
      if (wr) m_on = wdata[31];
      if (wr && !m_push) m_ovf = 1;
      if (m_pop) begin
        e = mq.pop_front();
        m_rs = e[8]; m_data = e[7:0]; k_pop = cyc;
        t_free = cyc + TS + TP + TH + ((!e[8] && e[7:0] >= 1 && e[7:0] <= 3) ? TL : TE) + 1;
      end
      if (m_push) mq.push_back({wdata[8], wdata[7:0]});
      m_en = (cyc - k_pop >= TS) && (cyc - k_pop < TS + TP);
    end
  endtask

  initial forever begin @(posedge clk); model_step(); end

  logic en_prev = 0;
  logic [8:0] bus_prev = 0;
  logic [8:0] got[$];
  int stable_viol = 0;
  initial forever begin
    @(negedge clk);
    if (lcd_en && !en_prev) got.push_back({lcd_rs, lcd_data});
    if (lcd_en && en_prev && {lcd_rs, lcd_data} != bus_prev) stable_viol++;
    en_prev = lcd_en;
    bus_prev = {lcd_rs, lcd_data};
  end

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while ((status[0] !== 1'b0 || lcd_en !== 1'b0) && cycles < 500) begin
      @(negedge clk); cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; wr = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data} !== 12'h0) begin
      n_fail++; $display("FAIL reset_pins got %h expected 000", {lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data});
    end
    n_tests++;
    if (lcd_oe !== 1'b1) begin n_fail++; $display("FAIL reset_oe got %b expected 1", lcd_oe); end
    n_tests++;
    if (status !== 32'h8) begin n_fail++; $display("FAIL reset_status got %h expected 00000008", status); end
    rst_n = 1;
    @(negedge clk);
    n_tests++;
    if (status !== 32'h8) begin n_fail++; $display("FAIL post_reset_status got %h expected 00000008", status); end
  endtask

  task automatic test_single();
    int n_set, n_pul, t;
    wait_idle(t);
    wr = 1; wdata = 32'h8000_0141;
    @(negedge clk); wr = 0;
    n_tests++;
    if (lcd_on !== 1'b1 || lcd_en !== 1'b0) begin
      n_fail++; $display("FAIL single_on got on=%b en=%b expected on=1 en=0", lcd_on, lcd_en);
    end
    @(negedge clk);
    n_tests++;
    if ({lcd_rs, lcd_data} !== 9'h141) begin
      n_fail++; $display("FAIL single_bus got %h expected 141", {lcd_rs, lcd_data});
    end
    n_set = 0;
    while (!lcd_en && n_set < 50) begin n_set++; @(negedge clk); end
    n_tests++;
    if (n_set != TS) begin n_fail++; $display("FAIL single_setup got %0d expected %0d", n_set, TS); end
    n_pul = 0;
    while (lcd_en && n_pul < 50) begin n_pul++; @(negedge clk); end
    n_tests++;
    if (n_pul != TP) begin n_fail++; $display("FAIL single_pulse got %0d expected %0d", n_pul, TP); end
    n_tests++;
    if ({lcd_rs, lcd_data} !== 9'h141) begin
      n_fail++; $display("FAIL single_hold_bus got %h expected 141", {lcd_rs, lcd_data});
    end
    t = n_set + n_pul;
    while (status[0] && t < 200) begin t++; @(negedge clk); end
    n_tests++;
    if (t != TS + TP + TH + TE + 1) begin
      n_fail++; $display("FAIL single_busy_len got %0d expected %0d", t, TS + TP + TH + TE + 1);
    end
  endtask

  task automatic test_long();
    logic [8:0] cmd[6] = '{9'h001, 9'h038, 9'h003, 9'h101, 9'h004, 9'h002};
    int ex[6] = '{TL, TE, TL, TE, TE, TL};
    int t;
    for (int i = 0; i < 6; i++) begin
      wait_idle(t);
      wr = 1; wdata = {23'b0, cmd[i]};
      @(negedge clk); wr = 0;
      @(negedge clk);
      t = 0;
      while (status[0] && t < 300) begin t++; @(negedge clk); end
      n_tests++;
      if (t != TS + TP + TH + ex[i] + 1) begin
        n_fail++; $display("FAIL exec_len cmd=%h got %0d expected %0d", cmd[i], t, TS + TP + TH + ex[i] + 1);
      end
    end
  endtask

  task automatic test_overflow();
    logic [8:0] w[6];
    int base, t;
    wait_idle(t);
    base = got.size();
    for (int i = 0; i < 6; i++) w[i] = {1'b1, 8'($urandom)};
    for (int i = 0; i < 6; i++) begin wr = 1; wdata = {23'b0, w[i]}; @(negedge clk); end
    wr = 0;
    @(negedge clk);
    n_tests++;
    if (status !== 32'h47) begin n_fail++; $display("FAIL ovf_status got %h expected 00000047", status); end
    wait_idle(t);
    repeat (2) @(negedge clk);
    n_tests++;
    if (got.size() - base != 5) begin
      n_fail++; $display("FAIL ovf_count got %0d expected 5", got.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (base + i >= got.size() || got[base + i] !== w[i]) begin
        n_fail++; $display("FAIL ovf_order idx=%0d got %h expected %h", i,
                           (base + i < got.size()) ? got[base + i] : 9'h1ff, w[i]);
      end
    end
    n_tests++;
    if (status !== 32'hC) begin n_fail++; $display("FAIL ovf_sticky got %h expected 0000000c", status); end
  endtask

  task automatic test_reset_mid();
    int n, base;
    wait_idle(n);
    for (int i = 0; i < 3; i++) begin wr = 1; wdata = 32'h0000_0150 + i; @(negedge clk); end
    wr = 0;
    n = 0;
    while (!lcd_en && n < 20) begin @(negedge clk); n++; end
    n_tests++;
    if (lcd_en !== 1'b1) begin n_fail++; $display("FAIL mid_reach_pulse got en=%b expected 1", lcd_en); end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    n_tests++;
    if (lcd_en !== 1'b0) begin n_fail++; $display("FAIL mid_en got %b expected 0", lcd_en); end
    n_tests++;
    if (status !== 32'h8) begin n_fail++; $display("FAIL mid_status got %h expected 00000008", status); end
    @(negedge clk);
    base = got.size();
    repeat (100) @(negedge clk);
    n_tests++;
    if (got.size() != base || status !== 32'h8) begin
      n_fail++; $display("FAIL mid_quiet got transfers=%0d status=%h expected 0 and 00000008", got.size() - base, status);
    end
  endtask

  task automatic test_random();
    logic burst = 0;
    logic [8:0] w9;
    for (int i = 0; i < 1500; i++) begin
      n_tests++;
      if ({lcd_on, lcd_en, lcd_rs, lcd_data, lcd_rw, lcd_oe, status} !==
          {m_on, m_en, m_rs, m_data, 1'b0, 1'b1, m_status}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got on=%b en=%b rs=%b d=%h rw=%b oe=%b st=%h expected on=%b en=%b rs=%b d=%h rw=0 oe=1 st=%h",
                 i, lcd_on, lcd_en, lcd_rs, lcd_data, lcd_rw, lcd_oe, status, m_on, m_en, m_rs, m_data, m_status);
      end
      if (i % 150 == 0) burst = $urandom_range(0, 1) == 1;
      w9 = {1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom)};
      wdata = {$urandom} & 32'hFFFF_FE00 | {23'b0, w9};
      wr = burst ? $urandom_range(0, 2) == 0 : $urandom_range(0, 19) == 0;
      rst_n = $urandom_range(0, 299) != 0;
      lcd_din = 8'($urandom);
      @(negedge clk);
    end
    wr = 0; rst_n = 1;
    n_tests++;
    if (stable_viol != 0) begin n_fail++; $display("FAIL bus_stable got %0d changes expected 0", stable_viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_long();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Peripheral-side consumer of the CPU's memory-mapped LCD register.
- Software writes command/data words, which are queued in a small FIFO.
- Each entry is serialized onto an HD44780-style 8-bit parallel bus with the required setup, enable-pulse, hold and execution timing.
- Status (busy/full/overflow/level) is returned as a 32-bit word for the load path.

Parameters:
- FIFO_DEPTH, 4, queue entries; power of two, minimum 2.
- T_SETUP, 2, cycles RS/DATA are stable before EN rises (min 1).
- T_PULSE, 12, cycles EN is held high (min 1).
- T_HOLD, 2, cycles RS/DATA are held after EN falls (min 1).
- T_EXEC, 2000, wait cycles after a normal command/data write.
- T_EXEC_LONG, 82000, wait cycles after clear/home commands.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-low reset.
- i_wr  in  1  write strobe (LCD address decoded AND store).
- i_wdata  in  32  [31] display on, [8] RS, [7:0] byte; other bits ignored.
- o_status  out  32  [0] busy, [1] full, [2] overflow, [3] empty, [7:4] FIFO level, others 0.
- o_lcd_on  out  1  display power/backlight.
- o_lcd_en  out  1  LCD enable strobe.
- o_lcd_rs  out  1  register select.
- o_lcd_rw  out  1  read/write (0 = write).
- o_lcd_data  out  8  LCD data bus, output value.
- o_lcd_data_oe  out  1  data bus output enable.
- i_lcd_data  in  8  LCD data bus, input value.

Behaviour:
- Reset (i_reset=0 at a rising edge) forces:
  - FIFO empty, FSM in IDLE, all counters 0, overflow 0.
  - o_lcd_on=0, o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0, o_lcd_data_oe=1.
  - Reset mid-transfer aborts immediately, with EN low on the next cycle.
- Write acceptance (i_wr=1):
  - o_lcd_on <= i_wdata[31] on every write, including dropped ones.
  - {i_wdata[8], i_wdata[7:0]} is pushed if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the entry is dropped and the sticky overflow flag is set; overflow clears only on reset.
- FSM states: IDLE, SETUP, PULSE, HOLD, EXEC. All outputs are registered.
  - IDLE: if FIFO non-empty, pop; at that edge load o_lcd_rs/o_lcd_data, set rw=0, go to SETUP. With an idle FSM, pins update on the 2nd rising edge after the i_wr edge.
  - SETUP: en=0 for T_SETUP cycles, then go to PULSE.
  - PULSE: en=1 for exactly T_PULSE cycles, then go to HOLD.
  - HOLD: en=0, pins held for T_HOLD cycles, then go to EXEC.
  - EXEC: wait T_EXEC_LONG cycles if rs=0 and data is 0x01, 0x02 or 0x03; otherwise wait T_EXEC. Then go to IDLE.
- Pin behaviour: RS/DATA change only on entry to SETUP; they are never changed while EN is high.
- busy = (FSM != IDLE) | ~empty.
- Level: count of queued entries, saturating at FIFO_DEPTH; wraps internally via pointers of width log2(FIFO_DEPTH)+1.
- Counters: down-counters loaded on state entry, sized for T_EXEC_LONG.

Optional Feature:
- Macro: LCD_BUSY_POLL_EN.
- When defined, EXEC is replaced by POLL, which repeats the following until the sampled bit 7 is 0, then goes to IDLE:
  - Set rs=0, rw=1, oe=0; wait T_SETUP.
  - Raise en for T_PULSE; sample i_lcd_data[7] on the last PULSE cycle.
  - Lower en and wait T_HOLD.
  - Restore rw=0, oe=1.
- T_EXEC/T_EXEC_LONG then act only as a timeout: if the busy flag is still set after T_EXEC_LONG cycles, POLL exits to IDLE anyway.
- When undefined: fixed delays as described above; o_lcd_rw is constant 0, o_lcd_data_oe is constant 1, i_lcd_data is ignored.

Test Plan:
Bench parameters: T_SETUP=1, T_PULSE=3, T_HOLD=1, T_EXEC=10, T_EXEC_LONG=50, FIFO_DEPTH=4.
- Reset check: hold i_reset=0 for 3 cycles -> all pins 0, oe=1, o_status=0x00000008.
- Single write: write 0x80000141 -> o_lcd_on=1; rs=1 and data=0x41 two edges later; en high exactly 3 cycles after 1 setup cycle; busy clears 1+1+3+1+10 cycles after the pop.
- Long command: write 0x00000001 -> EXEC lasts 50 cycles. Write 0x00000038 -> EXEC lasts 10 cycles.
- Overflow: write 6 words back-to-back starting from idle -> 1 popped, 4 queued, 6th dropped. o_status full=1, overflow=1, level=4. Bus then emits exactly 5 transfers in order.
- Reset mid-transfer: assert reset during PULSE -> en=0 next cycle, FIFO empty, overflow cleared, no further transfers.
- Busy polling (LCD_BUSY_POLL_EN defined): drive i_lcd_data[7]=1 for 2 polls, then 0 -> 3 read pulses with rw=1, oe=0, then IDLE. Hold bit 7 at 1 -> exit after 50 cycles.
